rv_muldiv_unit: RTL

- Iterative multi-cycle multiply/divide unit implementing the RV32M/RV64M funct3 set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for operands of width WIDTH.
- Sits beside the single-cycle integer ALU in the execute stage. It is selected when opcode 0110011 and funct7 0000001.
- Uses a valid/ready handshake on input and output so the core can stall while the unit is busy.
- Carries a destination-register tag through to writeback.

---
 rtl/rv_muldiv_unit.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/rv_muldiv_unit.sv
// ============================================================================
// Module      : rv_muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide unit with valid/ready
//               handshake and a pass-through destination-register tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_busy  = 2'd1;
    localparam logic [1:0] c_st_fixup = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [WIDTH-1:0] c_int_min = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_funct3;
    logic [TAG_W-1:0]   r_tag;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_result;
    logic [TAG_W-1:0]   r_out_tag;

    // Operand decode at accept
    logic               w_accept;
    logic               w_signed_a;
    logic               w_signed_b;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_div0;
    logic               w_ovf;
    logic               w_fast;
    logic [WIDTH-1:0]   w_fast_res;

    // Iteration datapath
    logic [WIDTH:0]     w_sum;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH+1:0]   w_diff;

    // Fixup datapath
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_fix_res;

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state != c_st_idle);
    assign result    = r_result;
    assign out_tag   = r_out_tag;

    always_comb begin
        w_accept   = in_valid && (r_state == c_st_idle) && !flush;
        w_signed_a = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        w_signed_b = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        w_neg_a    = w_signed_a && rs1[WIDTH-1];
        w_neg_b    = w_signed_b && rs2[WIDTH-1];
        w_mag_a    = w_neg_a ? -rs1 : rs1;
        w_mag_b    = w_neg_b ? -rs2 : rs2;
        w_div0     = funct3[2] && (rs2 == '0);
        w_ovf      = ((funct3 == 3'd4) || (funct3 == 3'd6)) && (rs1 == c_int_min) && (rs2 == '1);
        w_fast     = w_div0 || w_ovf;
        w_fast_res = '0;
        if (w_div0) begin
            w_fast_res = funct3[1] ? rs1 : '1;
        end else if (w_ovf) begin
            w_fast_res = funct3[1] ? '0 : rs1;
        end
    end

    // Shift-add multiply keeps the multiplier in the low half and shifts right.
    // Restoring divide shifts dividend bits out of r_quo into the remainder.
    always_comb begin
        w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_diff  = w_shift - {2'b00, r_b};
    end

    always_comb begin
        w_prod_fix = r_neg_q ? -r_prod : r_prod;
        w_quo_fix  = r_neg_q ? -r_quo : r_quo;
        w_rem_fix  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        case (r_funct3)
            3'd0:                   w_fix_res = w_prod_fix[WIDTH-1:0];
            3'd1, 3'd2, 3'd3:       w_fix_res = w_prod_fix[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:             w_fix_res = w_quo_fix;
            default:                w_fix_res = w_rem_fix;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = w_fast ? c_st_done : c_st_busy;
                end
            end
            c_st_busy: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = c_st_fixup;
                end
            end
            c_st_fixup: w_state_nxt = c_st_done;
            c_st_done: begin
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
        if (flush) begin
            w_state_nxt = c_st_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_tag     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_result  <= '0;
            r_out_tag <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_funct3 <= funct3;
                        r_tag    <= in_tag;
                        r_neg_q  <= w_neg_a ^ w_neg_b;
                        r_neg_r  <= w_neg_a;
                        r_a      <= w_mag_a;
                        r_b      <= w_mag_b;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_prod   <= {{WIDTH{1'b0}}, w_mag_b};
                        r_rem    <= '0;
                        r_quo    <= w_mag_a;
                        if (w_fast) begin
                            r_result  <= w_fast_res;
                            r_out_tag <= in_tag;
                        end
                    end
                end
                c_st_busy: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_funct3[2]) begin
                        if (!w_diff[WIDTH+1]) begin
                            r_rem <= w_diff[WIDTH:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
                    end
                end
                c_st_fixup: begin
                    r_result  <= w_fix_res;
                    r_out_tag <= r_tag;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
